// File: rtl/mux_bin_pkg.sv
// mux_bin shared definitions: architecture selectors
// and the tree-depth helper.
package mux_bin_pkg;

  localparam int IMP_INDEX = 0;
  localparam int IMP_TREE  = 1;

  function automatic int ceil_div(
    input int a,
    input int b
  );
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/mux_bin_leaf.sv
// mux_bin_leaf: one SPLIT-input selection stage
// of the tree architecture.
module mux_bin_leaf
  import mux_bin_pkg::*;
#(
  parameter type DAT_T = logic [7:0],
  parameter int  SPLIT = 4,
  localparam int SPLIT_LOG = $clog2(SPLIT)
) (
  input  logic [SPLIT_LOG-1:0] sel,
  input  DAT_T                 ary [SPLIT-1:0],
  output DAT_T                 dat
);

  assign dat = ary[sel];

endmodule

// File: rtl/mux_bin.sv
// mux_bin: binary-select multiplexer, direct or tree.
// Define MUX_BIN_REG_EN for a registered output.
module mux_bin
  import mux_bin_pkg::*;
#(
  parameter type DAT_T          = logic [7:0],
  parameter int  WIDTH          = 16,
  parameter int  SPLIT          = 4,
  parameter int  IMPLEMENTATION = 0,
  localparam int WIDTH_LOG      = $clog2(WIDTH),
  localparam int SPLIT_LOG      = $clog2(SPLIT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH_LOG-1:0] bin,
  input  DAT_T                 ary [WIDTH-1:0],
  output DAT_T                 dat
);

  DAT_T nxt;

  if (IMPLEMENTATION == IMP_INDEX) begin : g_idx
    assign nxt = (32'(bin) < WIDTH) ? ary[bin] : '0;
  end else if (IMPLEMENTATION == IMP_TREE) begin : g_tree
    localparam int K  = ceil_div(WIDTH_LOG, SPLIT_LOG);
    localparam int N  = SPLIT ** K;
    localparam int SW = K * SPLIT_LOG;

    DAT_T          pad [N-1:0];
    logic [SW-1:0] sel;

    // Zero-extended select: the root uses fewer real bits.
    assign sel = SW'(bin);

    for (genvar i = 0; i < N; i++) begin : g_pad
      if (i < WIDTH) begin : g_d
        assign pad[i] = ary[i];
      end else begin : g_z
        assign pad[i] = '0;
      end
    end

    for (genvar l = 0; l < K; l++) begin : g_lvl
      localparam int CNT = SPLIT ** (K - l - 1);
      DAT_T node [CNT-1:0];
      for (genvar j = 0; j < CNT; j++) begin : g_n
        DAT_T in [SPLIT-1:0];
        for (genvar s = 0; s < SPLIT; s++) begin : g_i
          if (l == 0) begin : g_p
            assign in[s] = pad[j*SPLIT+s];
          end else begin : g_q
            assign in[s] = g_lvl[l-1].node[j*SPLIT+s];
          end
        end
        mux_bin_leaf #(
          .DAT_T (DAT_T),
          .SPLIT (SPLIT)
        ) u_leaf (
          .sel (sel[l*SPLIT_LOG +: SPLIT_LOG]),
          .ary (in),
          .dat (node[j])
        );
      end
    end

    assign nxt = g_lvl[K-1].node[0];
  end else begin : g_bad
    $error("mux_bin: unsupported IMPLEMENTATION %0d",
           IMPLEMENTATION);
  end

`ifdef MUX_BIN_REG_EN
  always_ff @(posedge clk) begin
    if (rst) dat <= '0;
    else     dat <= nxt;
  end
`else
  logic unused;
  assign unused = ^{clk, rst};
  assign dat    = nxt;
`endif

endmodule

// File: tb/tb_mux_bin.sv
// tb_mux_bin: directed table plus sweeps over three
// geometries and both architectures.
module tb_mux_bin;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] b16 = '0;
  logic [3:0] b10 = '0;
  logic [4:0] b32 = '0;
  logic [7:0] a16 [15:0];
  logic [7:0] a10 [9:0];
  logic [7:0] a32 [31:0];
  logic [7:0] d16_0, d16_1, d10_0, d10_1, d32_0, d32_1;

  int total = 0;
  int pass  = 0;

  always #5 clk = ~clk;

  mux_bin #(.WIDTH(16), .SPLIT(4), .IMPLEMENTATION(0)) u16i0 (
    .clk(clk), .rst(rst), .bin(b16), .ary(a16), .dat(d16_0));
  mux_bin #(.WIDTH(16), .SPLIT(4), .IMPLEMENTATION(1)) u16i1 (
    .clk(clk), .rst(rst), .bin(b16), .ary(a16), .dat(d16_1));
  mux_bin #(.WIDTH(10), .SPLIT(4), .IMPLEMENTATION(0)) u10i0 (
    .clk(clk), .rst(rst), .bin(b10), .ary(a10), .dat(d10_0));
  mux_bin #(.WIDTH(10), .SPLIT(4), .IMPLEMENTATION(1)) u10i1 (
    .clk(clk), .rst(rst), .bin(b10), .ary(a10), .dat(d10_1));
  mux_bin #(.WIDTH(32), .SPLIT(8), .IMPLEMENTATION(0)) u32i0 (
    .clk(clk), .rst(rst), .bin(b32), .ary(a32), .dat(d32_0));
  mux_bin #(.WIDTH(32), .SPLIT(8), .IMPLEMENTATION(1)) u32i1 (
    .clk(clk), .rst(rst), .bin(b32), .ary(a32), .dat(d32_1));

  typedef struct {
    int         cfg;
    int         bin;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string nm, input int idx,
                       input logic [7:0] act,
                       input logic [7:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s[%0d]: got %h expected %h",
               nm, idx, act, exp);
    else
      pass++;
  endtask

  task automatic settle();
`ifdef MUX_BIN_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic init_arrays();
    for (int i = 0; i < 16; i++) a16[i] = 8'(i);
    for (int i = 0; i < 10; i++) a10[i] = 8'(8'hA0 + i);
    for (int i = 0; i < 32; i++) a32[i] = 8'(i * 7 + 3);
  endtask

  task automatic apply(input int cfg, input int b);
    case (cfg)
      0:       b16 = 4'(b);
      1:       b10 = 4'(b);
      default: b32 = 5'(b);
    endcase
  endtask

  task automatic check_cfg(input string nm, input int cfg,
                           input int b, input logic [7:0] exp);
    case (cfg)
      0: begin
        check({nm, "_w16_idx"}, b, d16_0, exp);
        check({nm, "_w16_tree"}, b, d16_1, exp);
      end
      1: begin
        check({nm, "_w10_idx"}, b, d10_0, exp);
        check({nm, "_w10_tree"}, b, d10_1, exp);
      end
      default: begin
        check({nm, "_w32_idx"}, b, d32_0, exp);
        check({nm, "_w32_tree"}, b, d32_1, exp);
      end
    endcase
  endtask

  function automatic logic [7:0] model(input int cfg,
                                       input int b);
    case (cfg)
      0:       return 8'(b);
      1:       return (b < 10) ? 8'(8'hA0 + b) : 8'h00;
      default: return 8'(b * 7 + 3);
    endcase
  endfunction

  initial begin
    tbl[0]  = '{0, 0,  8'h00};
    tbl[1]  = '{0, 15, 8'h0F};
    tbl[2]  = '{0, 6,  8'h06};
    tbl[3]  = '{1, 0,  8'hA0};
    tbl[4]  = '{1, 9,  8'hA9};
    tbl[5]  = '{1, 10, 8'h00};
    tbl[6]  = '{1, 15, 8'h00};
    tbl[7]  = '{2, 0,  8'h03};
    tbl[8]  = '{2, 7,  8'h34};
    tbl[9]  = '{2, 8,  8'h3B};
    tbl[10] = '{2, 31, 8'hDC};
    tbl[11] = '{2, 16, 8'h73};

    init_arrays();
    b16 = 4'd2;
    b10 = 4'd2;
    b32 = 5'd2;
    settle();
`ifdef MUX_BIN_REG_EN
    check("reset_w16_idx", 0, d16_0, 8'h00);
    check("reset_w16_tree", 0, d16_1, 8'h00);
    check("reset_w32_tree", 0, d32_1, 8'h00);
`else
    check("comb_rst_w16_idx", 2, d16_0, 8'h02);
    check("comb_rst_w16_tree", 2, d16_1, 8'h02);
    check("comb_rst_w32_tree", 2, d32_1, 8'h11);
`endif
    rst = 1'b0;

    foreach (tbl[i]) begin
      apply(tbl[i].cfg, tbl[i].bin);
      settle();
      check_cfg("table", tbl[i].cfg, tbl[i].bin, tbl[i].exp);
    end

    for (int c = 0; c < 3; c++) begin
      for (int b = 0; b < ((c == 2) ? 32 : 16); b++) begin
        apply(c, b);
        settle();
        check_cfg("sweep", c, b, model(c, b));
      end
    end

    for (int i = 0; i < 16; i++) a16[i] = 8'($urandom);
    for (int i = 0; i < 32; i++) a32[i] = 8'($urandom);
    for (int n = 0; n < 1000; n++) begin
      b16 = 4'($urandom_range(15));
      b32 = 5'($urandom_range(31));
      settle();
      check("rand_w16_idx", n, d16_0, a16[b16]);
      check("rand_w16_tree", n, d16_1, a16[b16]);
      check("rand_w32_idx", n, d32_0, a32[b32]);
      check("rand_w32_tree", n, d32_1, a32[b32]);
    end

`ifdef MUX_BIN_REG_EN
    init_arrays();
    rst = 1'b1;
    b16 = 4'd9;
    for (int c = 0; c < 2; c++) begin
      settle();
      check("rst_hold_idx", c, d16_0, 8'h00);
      check("rst_hold_tree", c, d16_1, 8'h00);
    end
    rst = 1'b0;
    b16 = 4'd5;
    settle();
    check("release_idx", 5, d16_0, 8'h05);
    check("release_tree", 5, d16_1, 8'h05);

    for (int c = 0; c < 8; c++) begin
      b16 = 4'(c + 1);
      rst = (c == 3);
      settle();
      check("mid_rst_idx", c, d16_0,
            (c == 3) ? 8'h00 : 8'(c + 1));
      check("mid_rst_tree", c, d16_1,
            (c == 3) ? 8'h00 : 8'(c + 1));
    end
    rst = 1'b0;
`endif

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
